// File: rtl/g3_update_ctrl.sv
// g3_update_ctrl: write-side controller for one G3 search table.
// Allocates slots, builds chained entries and owns the chain head.
module g3_update_ctrl #(
    parameter int TABLE_ENTRY_SIZE = 63,
    parameter int INDEX_BIT_LEN    = 11,
    parameter int COMMAND_BIT_LEN  = 2,
    parameter int ENTRY_DATA_WIDTH = 171
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [COMMAND_BIT_LEN-1:0]    cmd_op,
    input  logic [INDEX_BIT_LEN-1:0]      cmd_index,
    input  logic [ENTRY_DATA_WIDTH-INDEX_BIT_LEN-1:0] cmd_rule,
    output logic                          we,
    output logic [INDEX_BIT_LEN-1:0]      wr_index,
    output logic [ENTRY_DATA_WIDTH-1:0]   din,
    output logic                          done,
    output logic [1:0]                    resp_status,
    output logic [INDEX_BIT_LEN-1:0]      resp_index,
    output logic [INDEX_BIT_LEN-1:0]      head_index,
    output logic [INDEX_BIT_LEN:0]        live_count
);

    localparam int DEPTH  = TABLE_ENTRY_SIZE + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int BODY_W = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;

    localparam logic [INDEX_BIT_LEN-1:0] NULL_IDX = '1;
    localparam logic [INDEX_BIT_LEN-1:0] MAX_IDX  = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
    localparam logic [AW:0]              MAX_PTR  = (AW+1)'(TABLE_ENTRY_SIZE);
    localparam logic [AW:0]              ONE_P    = (AW+1)'(1);
    localparam logic [INDEX_BIT_LEN:0]   ONE_C    = (INDEX_BIT_LEN+1)'(1);

    localparam logic [COMMAND_BIT_LEN-1:0] OP_INS = COMMAND_BIT_LEN'(1);
    localparam logic [COMMAND_BIT_LEN-1:0] OP_DEL = COMMAND_BIT_LEN'(2);
    localparam logic [COMMAND_BIT_LEN-1:0] OP_MOD = COMMAND_BIT_LEN'(3);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FULL = 2'b01;
    localparam logic [1:0] ST_BIDX = 2'b10;
    localparam logic [1:0] ST_BCMD = 2'b11;

    // Port ranges inverted (lo=FFFF, hi=0) so strict range compares never hit.
    localparam logic [BODY_W-1:0] TOMB =
        (BODY_W'(16'hFFFF) << 92) | (BODY_W'(16'hFFFF) << 124);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [COMMAND_BIT_LEN-1:0] r_op;
    logic [INDEX_BIT_LEN-1:0]   r_index;
    logic [BODY_W-1:0]          r_rule;
    logic [INDEX_BIT_LEN-1:0]   r_slot;
    logic [INDEX_BIT_LEN-1:0]   r_next;
    logic                       r_ok;
    logic                       r_append;
    logic [1:0]                 r_status;
    logic [INDEX_BIT_LEN-1:0]   r_resp_idx;
    logic [INDEX_BIT_LEN-1:0]   r_wr_index;
    logic [ENTRY_DATA_WIDTH-1:0] r_din;
    logic [INDEX_BIT_LEN-1:0]   r_head;
    logic [INDEX_BIT_LEN:0]     r_live_count;
    logic [DEPTH-1:0]           r_live;
    logic [AW:0]                r_sp;
    logic [AW:0]                r_alloc;
    logic [AW-1:0]              r_stack  [DEPTH];
    logic [INDEX_BIT_LEN-1:0]   r_shadow [DEPTH];

    logic                       w_accept;
    logic                       w_in_range;
    logic                       w_live_hit;
    logic [AW:0]                w_sp_m1;
    logic [AW-1:0]              w_top;
    logic [AW-1:0]              w_idx_lo;
    logic [AW-1:0]              w_slot_lo;
    logic [INDEX_BIT_LEN-1:0]   w_slot;
    logic [INDEX_BIT_LEN-1:0]   w_next;
    logic                       w_ok;
    logic                       w_pop;
    logic                       w_alloc;
    logic [1:0]                 w_status;
    logic [BODY_W-1:0]          w_body;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_idx_lo   = r_index[AW-1:0];
    assign w_slot_lo  = r_slot[AW-1:0];
    assign w_in_range = (r_index <= MAX_IDX);
    assign w_live_hit = w_in_range && r_live[w_idx_lo];
    assign w_sp_m1    = r_sp - ONE_P;
    assign w_top      = r_stack[w_sp_m1[AW-1:0]];
    assign w_body     = (r_op == OP_DEL) ? TOMB : r_rule;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: fixed four-cycle command walk
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs from state
    always_comb begin
        cmd_ready = (r_state == S_IDLE) && rst_n;
        we        = (r_state == S_WRITE) && r_ok;
        done      = (r_state == S_RESP);
    end

    // Command decode and validation, evaluated during EXEC
    always_comb begin
        w_slot   = NULL_IDX;
        w_next   = NULL_IDX;
        w_ok     = 1'b0;
        w_pop    = 1'b0;
        w_alloc  = 1'b0;
        w_status = ST_BCMD;
        case (r_op)
            OP_INS: begin
                if (r_sp != '0) begin
                    w_slot   = INDEX_BIT_LEN'(w_top);
                    w_next   = r_shadow[w_top];
                    w_ok     = 1'b1;
                    w_pop    = 1'b1;
                    w_status = ST_OK;
                end else if (r_alloc <= MAX_PTR) begin
                    w_slot   = INDEX_BIT_LEN'(r_alloc);
                    w_next   = r_head;
                    w_ok     = 1'b1;
                    w_alloc  = 1'b1;
                    w_status = ST_OK;
                end else begin
                    w_status = ST_FULL;
                end
            end
            OP_DEL, OP_MOD: begin
                if (w_live_hit) begin
                    w_slot   = r_index;
                    w_next   = r_shadow[w_idx_lo];
                    w_ok     = 1'b1;
                    w_status = ST_OK;
                end else begin
                    w_status = ST_BIDX;
                end
            end
            default: w_status = ST_BCMD;
        endcase
    end

    // Capture, allocation, write-port and chain bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_index      <= '0;
            r_rule       <= '0;
            r_slot       <= '0;
            r_next       <= NULL_IDX;
            r_ok         <= 1'b0;
            r_append     <= 1'b0;
            r_status     <= ST_OK;
            r_resp_idx   <= NULL_IDX;
            r_wr_index   <= '0;
            r_din        <= '0;
            r_head       <= NULL_IDX;
            r_live_count <= '0;
            r_live       <= '0;
            r_sp         <= '0;
            r_alloc      <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_index <= cmd_index;
                r_rule  <= cmd_rule;
            end
            if (r_state == S_EXEC) begin
                r_slot     <= w_slot;
                r_next     <= w_next;
                r_ok       <= w_ok;
                r_append   <= w_alloc;
                r_status   <= w_status;
                r_resp_idx <= w_ok ? w_slot : NULL_IDX;
                if (w_pop)   r_sp    <= w_sp_m1;
                if (w_alloc) r_alloc <= r_alloc + ONE_P;
                if (w_ok) begin
                    r_wr_index <= w_slot;
                    r_din      <= {w_next, w_body};
                end
            end
            if (r_state == S_WRITE && r_ok) begin
                if (r_append) r_head <= r_slot;
                if (r_op == OP_INS) begin
                    r_live[w_slot_lo] <= 1'b1;
                    r_live_count      <= r_live_count + ONE_C;
                end
                if (r_op == OP_DEL) begin
                    r_live[w_slot_lo] <= 1'b0;
                    r_live_count      <= r_live_count - ONE_C;
                    r_sp              <= r_sp + ONE_P;
                end
            end
        end
    end

    // Free stack and shadow next array; contents need no reset
    always_ff @(posedge clk) begin
        if (r_state == S_WRITE && r_ok) begin
            r_shadow[w_slot_lo] <= r_next;
            if (r_op == OP_DEL) r_stack[r_sp[AW-1:0]] <= w_slot_lo;
        end
    end

    assign wr_index    = r_wr_index;
    assign din         = r_din;
    assign resp_status = r_status;
    assign resp_index  = r_resp_idx;
    assign head_index  = r_head;
    assign live_count  = r_live_count;

endmodule

// File: tb/tb_g3_update_ctrl.sv
// tb_g3_update_ctrl: directed vector bench for g3_update_ctrl.
// Table of commands plus fill, full and mid-write reset sequences.
module tb_g3_update_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [10:0]  cmd_index;
    logic [159:0] cmd_rule;
    logic         we;
    logic [10:0]  wr_index;
    logic [170:0] din;
    logic         done;
    logic [1:0]   resp_status;
    logic [10:0]  resp_index;
    logic [10:0]  head_index;
    logic [11:0]  live_count;

    g3_update_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_index   (cmd_index),
        .cmd_rule    (cmd_rule),
        .we          (we),
        .wr_index    (wr_index),
        .din         (din),
        .done        (done),
        .resp_status (resp_status),
        .resp_index  (resp_index),
        .head_index  (head_index),
        .live_count  (live_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [10:0]  idx;
        logic [159:0] rule;
        logic         ew;
        logic [10:0]  ewi;
        logic [10:0]  enext;
        logic [159:0] ebody;
        logic [1:0]   est;
        logic [10:0]  eri;
        logic [10:0]  ehead;
        logic [11:0]  elive;
    } vec_t;

    localparam logic [10:0] NUL = 11'h7FF;

    int n_pass  = 0;
    int n_total = 0;

    int           g_we_cnt;
    int           g_we_pos;
    int           g_done_cnt;
    int           g_done_pos;
    logic [10:0]  g_wi;
    logic [170:0] g_din;
    logic [1:0]   g_st;
    logic [10:0]  g_ri;
    logic [10:0]  g_head;
    logic [11:0]  g_live;

    logic [159:0] tomb;
    logic [159:0] ra, rb, rc, rd, re, rf;
    vec_t         tv [11];

    task automatic chk(input string nm, input logic [170:0] got,
                       input logic [170:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [159:0] mk_rule(input int id, input int x);
        logic [159:0] r;
        r = '0;
        r[159:149] = 11'(id);
        r[31:0]    = 32'(x);
        r[107:92]  = 16'(x + 3);
        r[91:76]   = 16'(x + 900);
        return r;
    endfunction

    // Issue one command and record everything seen over the next 4 cycles
    task automatic issue(input logic [1:0] op, input logic [10:0] idx,
                         input logic [159:0] rule);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 171'(cmd_ready), 171'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_index = idx;
        cmd_rule  = rule;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        g_we_cnt   = 0;
        g_we_pos   = 0;
        g_done_cnt = 0;
        g_done_pos = 0;
        for (int c = 1; c <= 4; c++) begin
            if (we) begin
                g_we_cnt++;
                g_we_pos = c;
                g_wi     = wr_index;
                g_din    = din;
            end
            if (done) begin
                g_done_cnt++;
                g_done_pos = c;
                g_st       = resp_status;
                g_ri       = resp_index;
                g_head     = head_index;
                g_live     = live_count;
            end
            if (c < 4) @(negedge clk);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " we_cnt"}, 171'(g_we_cnt), 171'(v.ew));
        if (v.ew) begin
            chk({tag, " we_pos"}, 171'(g_we_pos), 171'(2));
            chk({tag, " wr_index"}, 171'(g_wi), 171'(v.ewi));
            chk({tag, " next"}, 171'(g_din[170:160]), 171'(v.enext));
            chk({tag, " body"}, 171'(g_din[159:0]), 171'(v.ebody));
        end
        chk({tag, " done_cnt"}, 171'(g_done_cnt), 171'(1));
        chk({tag, " done_pos"}, 171'(g_done_pos), 171'(3));
        chk({tag, " status"}, 171'(g_st), 171'(v.est));
        chk({tag, " resp_index"}, 171'(g_ri), 171'(v.eri));
        chk({tag, " head"}, 171'(g_head), 171'(v.ehead));
        chk({tag, " live"}, 171'(g_live), 171'(v.elive));
    endtask

    function automatic vec_t mk(
        input logic [1:0] op, input logic [10:0] idx,
        input logic [159:0] rule, input logic ew,
        input logic [10:0] ewi, input logic [10:0] enext,
        input logic [159:0] ebody, input logic [1:0] est,
        input logic [10:0] eri, input logic [10:0] ehead,
        input logic [11:0] elive);
        vec_t v;
        v.op = op; v.idx = idx; v.rule = rule; v.ew = ew;
        v.ewi = ewi; v.enext = enext; v.ebody = ebody; v.est = est;
        v.eri = eri; v.ehead = ehead; v.elive = elive;
        return v;
    endfunction

    initial begin
        vec_t v;

        tomb = '0;
        tomb[107:92]  = 16'hFFFF;
        tomb[139:124] = 16'hFFFF;
        ra = mk_rule(5, 'h111);
        rb = mk_rule(9, 'h222);
        rc = mk_rule(12, 'h333);
        rd = mk_rule(20, 'h444);
        re = mk_rule(33, 'h555);
        rf = mk_rule(40, 'h666);

        tv[0]  = mk(2'b01, 11'd0, ra, 1, 0, NUL, ra, 2'b00, 0, 0, 1);
        tv[1]  = mk(2'b01, 11'd0, rb, 1, 1, 0, rb, 2'b00, 1, 1, 2);
        tv[2]  = mk(2'b10, 11'd0, '0, 1, 0, NUL, tomb, 2'b00, 0, 1, 1);
        tv[3]  = mk(2'b01, 11'd7, rc, 1, 0, NUL, rc, 2'b00, 0, 1, 2);
        tv[4]  = mk(2'b10, 11'd5, '0, 0, 0, 0, '0, 2'b10, NUL, 1, 2);
        tv[5]  = mk(2'b11, 11'd64, rd, 0, 0, 0, '0, 2'b10, NUL, 1, 2);
        tv[6]  = mk(2'b00, 11'd1, rd, 0, 0, 0, '0, 2'b11, NUL, 1, 2);
        tv[7]  = mk(2'b11, 11'd1, rd, 1, 1, 0, rd, 2'b00, 1, 1, 2);
        tv[8]  = mk(2'b10, 11'd1, '0, 1, 1, 0, tomb, 2'b00, 1, 1, 1);
        tv[9]  = mk(2'b11, 11'd1, rd, 0, 0, 0, '0, 2'b10, NUL, 1, 1);
        tv[10] = mk(2'b01, 11'd0, re, 1, 1, 0, re, 2'b00, 1, 1, 2);

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_index = '0;
        cmd_rule  = '0;
        repeat (2) @(negedge clk);
        chk("rst cmd_ready", 171'(cmd_ready), 171'(0));
        chk("rst we", 171'(we), 171'(0));
        chk("rst done", 171'(done), 171'(0));
        chk("rst status", 171'(resp_status), 171'(0));
        chk("rst resp_index", 171'(resp_index), 171'(NUL));
        chk("rst wr_index", 171'(wr_index), 171'(0));
        chk("rst din", din, 171'(0));
        chk("rst head", 171'(head_index), 171'(NUL));
        chk("rst live", 171'(live_count), 171'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(tv[i].op, tv[i].idx, tv[i].rule);
            check_vec($sformatf("vec%0d", i), tv[i]);
        end

        // Append-fill slots 2..63: each links to the previous head
        for (int s = 2; s <= 63; s++) begin
            v = mk(2'b01, 0, mk_rule(s, s), 1, 11'(s), 11'(s - 1),
                   mk_rule(s, s), 2'b00, 11'(s), 11'(s), 12'(s + 1));
            issue(v.op, v.idx, v.rule);
            check_vec($sformatf("fill%0d", s), v);
        end

        v = mk(2'b01, 0, rf, 0, 0, 0, '0, 2'b01, NUL, 63, 64);
        issue(v.op, v.idx, v.rule);
        check_vec("full", v);

        v = mk(2'b11, 11'd63, rf, 1, 63, 62, rf, 2'b00, 63, 63, 64);
        issue(v.op, v.idx, v.rule);
        check_vec("mod63", v);

        // Reset asserted while delete of slot 10 is in its write cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_index = 11'd10;
        cmd_rule  = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstw we before", 171'(we), 171'(1));
        chk("rstw wi before", 171'(wr_index), 171'(10));
        rst_n = 1'b0;
        #1;
        chk("rstw we", 171'(we), 171'(0));
        chk("rstw done", 171'(done), 171'(0));
        chk("rstw cmd_ready", 171'(cmd_ready), 171'(0));
        chk("rstw head", 171'(head_index), 171'(NUL));
        chk("rstw live", 171'(live_count), 171'(0));
        @(negedge clk);
        rst_n = 1'b1;

        v = mk(2'b01, 0, ra, 1, 0, NUL, ra, 2'b00, 0, 0, 1);
        issue(v.op, v.idx, v.rule);
        check_vec("post_rst", v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/g3_update_ctrl.md
Name: g3_update_ctrl

Overview:
- Write-side controller for one G3 search table.
- Accepts insert/delete/modify commands through a valid/ready handshake and allocates entry indices.
- Builds the full 171-bit entry, including the chain's next_index field, and drives the table's we/search_index/din write port.
- Owns the chain head pointer. The search pipeline starts each walk from head_index.

Parameters:
- TABLE_ENTRY_SIZE, 63: highest table index; table holds entries 0..TABLE_ENTRY_SIZE; must be < 2^INDEX_BIT_LEN-1.
- INDEX_BIT_LEN, 11: index/pointer width. All-ones is the NULL pointer (end of chain).
- COMMAND_BIT_LEN, 2: command opcode width.
- ENTRY_DATA_WIDTH, 171: table entry width; [170:160] next_index, [159:0] rule body.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: controller can accept a command.
- cmd_op, input, COMMAND_BIT_LEN: 00 invalid, 01 insert, 10 delete, 11 modify.
- cmd_index, input, INDEX_BIT_LEN: target index for delete/modify; ignored for insert.
- cmd_rule, input, 160: rule body [159:0] for insert/modify. Layout: ruleID [159:149], proto wildcard [148], port/IP fields below.
- we, output, 1: table write enable.
- wr_index, output, INDEX_BIT_LEN: table index; connects to the table's search_index during writes.
- din, output, ENTRY_DATA_WIDTH: entry to write.
- done, output, 1: one-cycle completion pulse.
- resp_status, output, 2: 00 OK, 01 FULL, 10 BAD_INDEX, 11 BAD_CMD; valid while done=1.
- resp_index, output, INDEX_BIT_LEN: index written; NULL on error.
- head_index, output, INDEX_BIT_LEN: current chain head.
- live_count, output, INDEX_BIT_LEN+1: number of live rules.

Behaviour:
- Reset (async, rst_n=0):
  - cmd_ready=0, we=0, done=0, resp_status=00, resp_index=NULL, wr_index=0, din=0, head_index=NULL, live_count=0.
  - Allocation pointer alloc_ptr=0, free stack empty, live bitmap all 0, shadow next array contents don't-care.
  - Table contents are not touched; they are unreachable because head=NULL.
- FSM states: IDLE -> EXEC -> WRITE -> RESP -> IDLE.
  - cmd_ready=1 only in IDLE and only while rst_n=1.
  - A command is accepted when cmd_valid & cmd_ready; op, index and rule are captured at that edge.
- EXEC: decode and validate; no outputs change.
  - Insert with a non-empty free stack: pop the slot; next comes from the shadow next array; the head is unchanged.
  - Insert with an empty stack and alloc_ptr ≤ TABLE_ENTRY_SIZE: slot=alloc_ptr, next=head_index, then alloc_ptr++.
  - Insert otherwise: error FULL.
  - Delete/modify requires cmd_index ≤ TABLE_ENTRY_SIZE and live[cmd_index]=1; otherwise error BAD_INDEX.
  - Op 00: error BAD_CMD.
- WRITE: asserted only on a non-error command; on an error the cycle passes with we=0.
  - we=1 for exactly one cycle; wr_index=slot; din={next, body}.
  - Insert/modify: body=cmd_rule.
  - Delete: body=tombstone. Tombstone has srcPort lo [107:92]=FFFF, hi [91:76]=0000; dstPort lo [139:124]=FFFF, hi [123:108]=0000; all other body bits 0. Strict range compares then never match.
  - Delete keeps the link intact: next is always the shadow next of the slot. No predecessor relink is ever written.
  - Same cycle, on success: update live[slot]; push slot onto the free stack (delete); write shadow_next[slot]=next.
  - Append insert only: head_index<=slot.
  - live_count: +1 on insert, -1 on delete.
- RESP: done=1 for one cycle, with resp_status and resp_index. we=0. Return to IDLE.
- Latency: acceptance edge to the we cycle is 2 cycles; to done is 3 cycles. Throughput is one command per 4 cycles.
- Free stack depth is TABLE_ENTRY_SIZE+1. Pushes only occur for live indices, so it never overflows.
- A tombstoned slot stays in the chain forever and is reused first (LIFO). Deleted-then-reinserted rules keep their chain position.
- Modify never changes next, head, the free stack, or live_count.
- Reset mid-command aborts immediately: we and done drop at the asynchronous reset, and no partial state survives.
- cmd_valid held high after acceptance is not a new command until the FSM returns to IDLE.

Test Plan:
1. Reset, insert A (ruleID 5), then insert B (ruleID 9).
   - A: we at accept+2 with wr_index=0, din[170:160]=7FF; done at accept+3, status 00, resp_index 0.
   - B: wr_index=1, next=0; head_index=1; live_count=2.
2. Delete index 0, then insert C.
   - Delete writes index 0 with next=7FF, [107:92]=FFFF, [91:76]=0000, ruleID 0; live_count drops to 1.
   - C reuses index 0, next=7FF; head stays 1.
3. Fill all 64 entries, then insert once more.
   - Extra insert: done with status 01, resp_index 7FF; we never asserted; live_count stays 64.
4. Error commands, each answered by done with we=0:
   - Delete index 5 never allocated -> status 10.
   - Modify index 64 -> status 10.
   - cmd_op=00 -> status 11.
5. Modify index 1 with a new rule.
   - we with wr_index=1, next unchanged (0), new body; head and live_count unchanged.
6. Assert rst_n=0 during the WRITE state.
   - we, done and cmd_ready fall immediately; head_index=7FF, live_count=0.
   - After release, the first insert writes index 0.
